// File: rtl/tpu_pkg.sv
// Shared types and defaults for the systolic array job arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tpu_pkg;

    // Arbiter FSM states; S_START/S_WAIT/S_DONE are the "array owned" states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } arb_state_t;

    localparam int SYSARB_NUM_REQ_DEFAULT = 4;
    localparam int SYSARB_TIMEOUT_DEFAULT = 32;

endpackage

// File: rtl/systolic_job_arbiter_pick.sv
// Round-robin picker: first set req bit at or after rr_ptr, wrapping modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on found/idx.
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   rr_ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    // Scan offsets from farthest to nearest so the nearest hit to rr_ptr is the last write.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            int k;
            k = (int'(rr_ptr) + i) % NUM_REQ;
            if (req[k]) begin
                found = 1'b1;
                idx   = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/systolic_job_arbiter.sv
// Round-robin owner of the shared 4x4 systolic array; launches one job at a time. Optional watchdog: SYSARB_WATCHDOG_EN.
// Latency: req sampled in idle -> array_start/gnt next cycle; array_done -> job_done next cycle.
// Backpressure: req is a level held until gnt; only one job outstanding, no preemption.
module systolic_job_arbiter
    import tpu_pkg::*;
#(
    parameter int NUM_REQ        = SYSARB_NUM_REQ_DEFAULT,
    parameter int SEL_W          = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = SYSARB_TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] job_done,
    output logic [NUM_REQ-1:0] job_err,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               array_start,
    input  logic               array_done,
    output logic               array_abort,
    output logic [15:0]        jobs_completed
);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
            $error("systolic_job_arbiter: parameter out of range");
        end
    endgenerate

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   rr_ptr;
    logic [15:0]        jobs_cnt;
    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] sel_oh;
    logic               wd_expire;
    logic               aborted;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .SEL_W   (SEL_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .idx    (pick_idx)
    );

`ifdef SYSARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;

    // Expiry on the TIMEOUT_CYCLES-th wait cycle; a done in that same cycle wins.
    assign wd_expire = (state == S_WAIT) && !array_done &&
                       (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Wait-cycle counter (held at zero outside S_WAIT) and abort flag for the S_DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt  <= '0;
            aborted <= 1'b0;
        end else begin
            aborted <= wd_expire;
            if (state != S_WAIT) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end
`else
    assign wd_expire = 1'b0;
    assign aborted   = 1'b0;
`endif

    // State, owner index, round-robin pointer and completion counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            sel_q    <= '0;
            rr_ptr   <= '0;
            jobs_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && pick_found) begin
                sel_q <= pick_idx;
            end
            if (state == S_DONE) begin
                rr_ptr   <= (sel_q == SEL_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
                jobs_cnt <= jobs_cnt + 16'd1;
            end
        end
    end

    // Next-state and outputs, all decoded from registered state so req never reaches an output.
    always_comb begin
        state_nxt   = state;
        sel_oh      = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_q;
        gnt         = '0;
        job_done    = '0;
        job_err     = '0;
        array_start = 1'b0;
        array_abort = 1'b0;
        busy        = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (pick_found) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                array_start = 1'b1;
                gnt         = sel_oh;
                state_nxt   = S_WAIT;
            end
            S_WAIT: begin
                if (array_done || wd_expire) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                job_done    = sel_oh;
                job_err     = aborted ? sel_oh : '0;
                array_abort = aborted;
                state_nxt   = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign sel            = sel_q;
    assign jobs_completed = jobs_cnt;

endmodule
